// File: rtl/slot_bank_multi.sv
// slot_bank_multi: player balance register with a multi-bet spin sequencer.
// A spin deducts the selected bet up front, waits for the reel block to stop,
// classifies the captured digits and credits a multiplied, saturated payout.
module slot_bank_multi #(
  parameter int unsigned NUM_REELS    = 4,
  parameter int unsigned DIGIT_W      = 4,
  parameter int unsigned BAL_W        = 27,
  parameter int unsigned INIT_BALANCE = 100,
  parameter int unsigned MAX_BALANCE  = 99999999,
  parameter int unsigned JACKPOT_MULT = 10,
  parameter int unsigned PAIR_MULT    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           b1,
  input  logic                           b10,
  input  logic                           b50,
  input  logic                           b100,
  input  logic                           spin_req,
  input  logic                           reels_valid,
  input  logic [NUM_REELS*DIGIT_W-1:0]   reels,
  output logic [BAL_W-1:0]               balance,
  output logic                           busy,
  output logic                           win,
  output logic                           jackpot,
  output logic [BAL_W-1:0]               win_amount,
  output logic                           insufficient
);

  localparam logic [BAL_W-1:0] INIT_B = BAL_W'(INIT_BALANCE);
  localparam logic [BAL_W-1:0] MAX_B  = BAL_W'(MAX_BALANCE);
  localparam logic [BAL_W-1:0] JMULT  = BAL_W'(JACKPOT_MULT);
  localparam logic [BAL_W-1:0] PMULT  = BAL_W'(PAIR_MULT);

  typedef enum logic [1:0] {IDLE, WAIT, EVAL, PAY} state_t;

  state_t                         state, state_nxt;
  logic [BAL_W-1:0]               bet;
  logic [BAL_W-1:0]               bet_q;
  logic [BAL_W-1:0]               payout_q;
  logic [NUM_REELS*DIGIT_W-1:0]   reels_q;
  logic                           jack_q;
  logic                           all_eq;
  logic                           any_pair;
  logic                           accept;
  logic                           reject;
  logic [BAL_W:0]                 sum;

  // Bet decode with fixed priority b1 > b10 > b50 > b100
  always_comb begin
    bet = '0;
    if (b1)        bet = BAL_W'(1);
    else if (b10)  bet = BAL_W'(10);
    else if (b50)  bet = BAL_W'(50);
    else if (b100) bet = BAL_W'(100);
  end

  // Spin admission decisions; only meaningful in IDLE
  always_comb begin
    accept = (state == IDLE) && spin_req && (bet != '0) && (bet <= balance);
    reject = (state == IDLE) && spin_req && (bet > balance);
  end

  // Classify the captured reels: all-equal and any adjacent equal pair
  always_comb begin
    all_eq   = 1'b1;
    any_pair = 1'b0;
    for (int unsigned i = 1; i < NUM_REELS; i++) begin
      if (reels_q[i*DIGIT_W +: DIGIT_W] != reels_q[0 +: DIGIT_W])
        all_eq = 1'b0;
      if (reels_q[i*DIGIT_W +: DIGIT_W] == reels_q[(i-1)*DIGIT_W +: DIGIT_W])
        any_pair = 1'b1;
    end
  end

  // One bit wider than the balance so the credit can never wrap before clamping
  always_comb begin
    sum = {1'b0, balance} + {1'b0, payout_q};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and busy flag
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (reels_valid) state_nxt = EVAL;
      EVAL:    state_nxt = PAY;
      PAY:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Balance, latched spin data, payout and one-cycle result pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      balance      <= INIT_B;
      win_amount   <= '0;
      win          <= 1'b0;
      jackpot      <= 1'b0;
      insufficient <= 1'b0;
      bet_q        <= '0;
      reels_q      <= '0;
      payout_q     <= '0;
      jack_q       <= 1'b0;
    end else begin
      win          <= 1'b0;
      jackpot      <= 1'b0;
      insufficient <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            balance <= balance - bet;
            bet_q   <= bet;
          end else if (reject) begin
            insufficient <= 1'b1;
          end
        end
        WAIT: begin
          if (reels_valid) reels_q <= reels;
        end
        EVAL: begin
          jack_q <= all_eq;
          if (all_eq)        payout_q <= bet_q * JMULT;
          else if (any_pair) payout_q <= bet_q * PMULT;
          else               payout_q <= '0;
        end
        PAY: begin
          balance    <= (sum > {1'b0, MAX_B}) ? MAX_B : sum[BAL_W-1:0];
          win_amount <= payout_q;
          win        <= (payout_q != '0);
          jackpot    <= jack_q && (payout_q != '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slot_bank_multi.sv
// Scoreboard bench for slot_bank_multi: a driver issues spins and pushes the
// expected outcome computed from plain balance arithmetic; a monitor pops and
// compares whenever the DUT shows an acceptance, a completion or a rejection.
module tb_slot_bank_multi;

  localparam int NR = 4;
  localparam int DW = 4;
  localparam int RW = NR * DW;
  localparam int BW = 27;
  localparam longint SAT_MAX = 150;
  localparam longint DEF_MAX = 99999999;

  localparam int K_ACC  = 0;
  localparam int K_DONE = 1;
  localparam int K_INS  = 2;

  typedef struct {
    int     kind;
    longint bal;
    bit     w;
    bit     j;
    longint amt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          b1 = 1'b0, b10 = 1'b0, b50 = 1'b0, b100 = 1'b0;
  logic          spin_req = 1'b0, reels_valid = 1'b0;
  logic [RW-1:0] reels = '0;
  logic [BW-1:0] balance, win_amount;
  logic          busy, win, jackpot, insufficient;

  logic          s_spin = 1'b0, s_rv = 1'b0;
  logic [RW-1:0] s_reels = '0;
  logic [BW-1:0] s_balance, s_amount;
  logic          s_busy, s_win, s_jack, s_insuf;

  int     n_cmp = 0;
  int     n_bad = 0;
  exp_t   q[$];
  longint mbal = 100;
  longint smbal = 100;

  slot_bank_multi dut (
    .clk(clk), .rst(rst), .b1(b1), .b10(b10), .b50(b50), .b100(b100),
    .spin_req(spin_req), .reels_valid(reels_valid), .reels(reels),
    .balance(balance), .busy(busy), .win(win), .jackpot(jackpot),
    .win_amount(win_amount), .insufficient(insufficient)
  );

  slot_bank_multi #(.MAX_BALANCE(150)) dut_sat (
    .clk(clk), .rst(rst), .b1(b1), .b10(b10), .b50(b50), .b100(b100),
    .spin_req(s_spin), .reels_valid(s_rv), .reels(s_reels),
    .balance(s_balance), .busy(s_busy), .win(s_win), .jackpot(s_jack),
    .win_amount(s_amount), .insufficient(s_insuf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned bet_of(input logic [3:0] sw);
    if (sw[0]) return 1;
    if (sw[1]) return 10;
    if (sw[2]) return 50;
    if (sw[3]) return 100;
    return 0;
  endfunction

  // 2 = all reels equal, 1 = some adjacent pair, 0 = loss
  function automatic int classify(input logic [RW-1:0] rv);
    int d[NR];
    bit all_same, pair;
    for (int i = 0; i < NR; i++) d[i] = int'((rv >> (DW*i)) & RW'(15));
    all_same = 1'b1;
    pair     = 1'b0;
    for (int i = 1; i < NR; i++) begin
      if (d[i] != d[0])   all_same = 1'b0;
      if (d[i] == d[i-1]) pair     = 1'b1;
    end
    if (all_same) return 2;
    if (pair)     return 1;
    return 0;
  endfunction

  function automatic longint payout(input logic [RW-1:0] rv, input int unsigned bet);
    int c;
    c = classify(rv);
    if (c == 2) return longint'(bet) * 10;
    if (c == 1) return longint'(bet) * 2;
    return 0;
  endfunction

  function automatic longint lmin(input longint a, input longint b);
    return (a < b) ? a : b;
  endfunction

  task automatic push(input int kind, input longint bal, input bit w, input bit j, input longint amt);
    exp_t e;
    e.kind = kind; e.bal = bal; e.w = w; e.j = j; e.amt = amt;
    q.push_back(e);
  endtask

  task automatic expect_evt(input int kind);
    exp_t e;
    chk("event_pending", 64'(q.size() != 0), 64'd1);
    if (q.size() == 0) return;
    e = q.pop_front();
    chk("event_kind", 64'(kind), 64'(e.kind));
    chk("balance", 64'(balance), 64'(e.bal));
    if (kind == K_DONE) begin
      chk("win", 64'(win), 64'(e.w));
      chk("jackpot", 64'(jackpot), 64'(e.j));
      chk("win_amount", 64'(win_amount), 64'(e.amt));
    end
    if (kind == K_INS) chk("busy_after_reject", 64'(busy), 64'd0);
  endtask

  // Monitor: reacts to busy edges and rejection pulses on the main instance
  initial begin
    bit pb;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pb = 1'b0;
        continue;
      end
      if (!pb && busy) expect_evt(K_ACC);
      if (pb && !busy) expect_evt(K_DONE);
      else if (win || jackpot) chk("stray_win_pulse", 64'({win, jackpot}), 64'd0);
      if (insufficient) expect_evt(K_INS);
      pb = busy;
    end
  end

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mbal  = 100;
    smbal = 100;
    chk("rst_balance", 64'(balance), 64'd100);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pulses", 64'({win, jackpot, insufficient}), 64'd0);
    chk("rst_win_amount", 64'(win_amount), 64'd0);
  endtask

  task automatic do_spin(input logic [3:0] sw, input logic [RW-1:0] rv,
                         input int unsigned dly, input bit rv_in_idle);
    int unsigned bet;
    longint      pay;
    int          c;
    bet = bet_of(sw);
    {b100, b50, b10, b1} = sw;
    spin_req    = 1'b1;
    reels_valid = rv_in_idle;
    reels       = RW'($urandom);
    if (bet == 0) begin
      tick();
      spin_req = 1'b0; reels_valid = 1'b0;
      return;
    end
    if (longint'(bet) > mbal) begin
      push(K_INS, mbal, 1'b0, 1'b0, 0);
      tick();
      spin_req = 1'b0; reels_valid = 1'b0;
      return;
    end
    mbal = mbal - bet;
    push(K_ACC, mbal, 1'b0, 1'b0, 0);
    tick();
    reels_valid = 1'b0;
    for (int unsigned k = 0; k < dly; k++) begin
      spin_req = 1'($urandom);
      {b100, b50, b10, b1} = 4'($urandom);
      reels = RW'($urandom);
      tick();
    end
    spin_req    = 1'b0;
    reels       = rv;
    reels_valid = 1'b1;
    pay  = payout(rv, bet);
    c    = classify(rv);
    mbal = lmin(mbal + pay, DEF_MAX);
    push(K_DONE, mbal, pay != 0, c == 2, pay);
    tick();
    reels_valid = 1'b0;
    reels = RW'($urandom);
    for (int n = 0; n < 8 && busy; n++) tick();
    chk("spin_completes", 64'(busy), 64'd0);
  endtask

  task automatic sat_spin(input logic [3:0] sw, input logic [RW-1:0] rv);
    int unsigned bet;
    bet = bet_of(sw);
    {b100, b50, b10, b1} = sw;
    s_spin = 1'b1;
    tick();
    s_spin = 1'b0;
    {b100, b50, b10, b1} = 4'b0;
    smbal = smbal - bet;
    chk("sat_deduct", 64'(s_balance), 64'(smbal));
    s_reels = rv;
    s_rv    = 1'b1;
    tick();
    s_rv = 1'b0;
    tick();
    tick();
    smbal = lmin(smbal + payout(rv, bet), SAT_MAX);
    chk("sat_balance", 64'(s_balance), 64'(smbal));
    chk("sat_win", 64'(s_win), 64'(payout(rv, bet) != 0));
    chk("sat_win_amount", 64'(s_amount), 64'(payout(rv, bet)));
  endtask

  // Driver
  initial begin
    logic [3:0]    sw;
    logic [RW-1:0] rv;
    int unsigned   m;
    do_reset();

    do_spin(4'b0010, 16'h7777, 1, 1'b0);
    do_reset();
    do_spin(4'b1001, 16'h1123, 0, 1'b0);
    do_reset();
    do_spin(4'b0100, 16'h1234, 2, 1'b0);
    do_reset();
    do_spin(4'b1000, 16'h1234, 0, 1'b0);
    do_spin(4'b0001, 16'h1111, 0, 1'b0);
    do_spin(4'b0000, 16'h1111, 0, 1'b1);

    // Reset in WAIT: bet is forfeited and a late reels_valid credits nothing
    do_reset();
    b10 = 1'b1;
    spin_req = 1'b1;
    mbal = 90;
    push(K_ACC, mbal, 1'b0, 1'b0, 0);
    tick();
    spin_req = 1'b0;
    b10 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mbal = 100;
    chk("wait_rst_balance", 64'(balance), 64'd100);
    chk("wait_rst_busy", 64'(busy), 64'd0);
    reels = 16'h7777;
    reels_valid = 1'b1;
    tick();
    reels_valid = 1'b0;
    repeat (3) tick();
    chk("late_reels_balance", 64'(balance), 64'd100);
    chk("late_reels_amount", 64'(win_amount), 64'd0);

    // Saturation on the instance with a low ceiling
    do_reset();
    sat_spin(4'b0010, 16'h7777);
    sat_spin(4'b0010, 16'h3333);
    sat_spin(4'b1000, 16'h9999);
    sat_spin(4'b0001, 16'h5555);

    // Randomized spins
    for (int k = 0; k < 250; k++) begin
      sw = 4'($urandom);
      if ($urandom_range(0, 7) == 0) sw = 4'b0;
      m = $urandom_range(0, 99);
      if (m < 20) begin
        rv[DW-1:0] = DW'($urandom);
        for (int i = 1; i < NR; i++) rv[i*DW +: DW] = rv[DW-1:0];
      end else if (m < 60) begin
        for (int i = 0; i < NR; i++) rv[i*DW +: DW] = DW'($urandom_range(0, 2));
      end else begin
        rv = RW'($urandom);
      end
      if (mbal < 10 && $urandom_range(0, 3) == 0) do_reset();
      do_spin(sw, rv, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end

    repeat (4) tick();
    chk("leftover_expectations", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
